// File: rtl/pipeline_hazard_unit.sv
// Hazard, forwarding and freeze controller for the IF/ID/EX/MEM/WB pipeline.
// Define PIPELINE_HAZARD_FWD_EN to enable operand forwarding (only load-use stalls remain).
module pipeline_hazard_unit #(
  parameter int RIDX_W      = 4,
  parameter int NSRC        = 3,
  parameter int R0_ZERO     = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     id_valid,
  input  logic [NSRC*RIDX_W-1:0]   id_src_idx,
  input  logic [NSRC-1:0]          id_src_used,
  input  logic [RIDX_W-1:0]        id_dst_idx,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     ex_branch_taken,
  input  logic                     mem_busy,
  output logic                     pc_en,
  output logic                     if_id_en,
  output logic                     if_id_flush,
  output logic                     id_ex_flush,
  output logic                     ex_mem_en,
  output logic [NSRC*2-1:0]        fwd_sel,
  output logic                     mem_err,
  output logic [CNT_W-1:0]         stall_cnt
);

  // state        | meaning
  // S_RUN        | normal advance
  // S_STALL_DATA | one-cycle bubble insertion for a register hazard
  // S_STALL_MEM  | whole pipeline frozen while data memory is busy
  // S_FLUSH      | one-cycle squash of IF/ID and ID/EX after a taken branch
  typedef enum logic [1:0] {S_RUN, S_STALL_DATA, S_STALL_MEM, S_FLUSH} state_t;

  localparam int BW = $clog2(MEM_TIMEOUT + 1);

  state_t state_q, state_d;

  logic              ex_valid_q, ex_valid_d, ex_rw_q, ex_rw_d, ex_load_q, ex_load_d;
  logic [RIDX_W-1:0] ex_dst_q, ex_dst_d;
  logic              mem_valid_q, mem_valid_d, mem_rw_q, mem_rw_d;
  logic [RIDX_W-1:0] mem_dst_q, mem_dst_d;
  logic              wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d;
  logic [RIDX_W-1:0] wb_dst_q, wb_dst_d;
`ifdef PIPELINE_HAZARD_FWD_EN
  logic [NSRC*RIDX_W-1:0] ex_src_q, ex_src_d;
  logic [NSRC-1:0]        ex_used_q, ex_used_d;
`endif

  logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic freeze, flush, stall, data_stall;

  // Index 0 is hard-wired when R0_ZERO is set, so it never carries a dependency.
  function automatic logic live(input logic [RIDX_W-1:0] d);
    return !((R0_ZERO != 0) && (d == '0));
  endfunction

  always_comb begin
    logic [RIDX_W-1:0] s;
    logic ld_use, hit_any;
    s       = '0;
    ld_use  = 1'b0;
    hit_any = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      s = id_src_idx[k*RIDX_W +: RIDX_W];
      if (id_valid && id_src_used[k]) begin
        if (ex_valid_q && ex_rw_q && ex_dst_q == s && live(ex_dst_q)) begin
          hit_any = 1'b1;
          if (ex_load_q) ld_use = 1'b1;
        end
        if (mem_valid_q && mem_rw_q && mem_dst_q == s && live(mem_dst_q)) hit_any = 1'b1;
        if (wb_valid_q && wb_rw_q && wb_dst_q == s && live(wb_dst_q)) hit_any = 1'b1;
      end
    end
`ifdef PIPELINE_HAZARD_FWD_EN
    data_stall = ld_use;
`else
    // The register file writes on the edge, so even a WB-slot producer must be waited out.
    data_stall = ld_use || hit_any;
`endif
  end

`ifdef PIPELINE_HAZARD_FWD_EN
  always_comb begin
    logic [RIDX_W-1:0] es;
    es      = '0;
    fwd_sel = '0;
    for (int k = 0; k < NSRC; k++) begin
      es = ex_src_q[k*RIDX_W +: RIDX_W];
      if (ex_valid_q && ex_used_q[k]) begin
        if (mem_valid_q && mem_rw_q && mem_dst_q == es && live(mem_dst_q))
          fwd_sel[k*2 +: 2] = 2'd1;
        else if (wb_valid_q && wb_rw_q && wb_dst_q == es && live(wb_dst_q))
          fwd_sel[k*2 +: 2] = 2'd2;
      end
    end
  end
`else
  assign fwd_sel = '0;
`endif

  assign freeze = !run || mem_busy;
  assign flush  = !freeze && ex_branch_taken;
  assign stall  = !freeze && !ex_branch_taken && data_stall;

  always_comb begin
    state_d = S_RUN;
    case (state_q)
      S_STALL_MEM: state_d = mem_busy ? S_STALL_MEM : S_RUN;
      default: begin
        if (mem_busy)   state_d = S_STALL_MEM;
        else if (flush) state_d = S_FLUSH;
        else if (stall) state_d = S_STALL_DATA;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    ex_mem_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if (flush) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    ex_valid_d  = ex_valid_q;  ex_rw_d  = ex_rw_q;  ex_load_d = ex_load_q;  ex_dst_d = ex_dst_q;
    mem_valid_d = mem_valid_q; mem_rw_d = mem_rw_q; mem_dst_d = mem_dst_q;
    wb_valid_d  = wb_valid_q;  wb_rw_d  = wb_rw_q;  wb_dst_d  = wb_dst_q;
`ifdef PIPELINE_HAZARD_FWD_EN
    ex_src_d  = ex_src_q;
    ex_used_d = ex_used_q;
`endif
    if (!freeze) begin
      mem_valid_d = ex_valid_q;  mem_rw_d = ex_rw_q;  mem_dst_d = ex_dst_q;
      wb_valid_d  = mem_valid_q; wb_rw_d  = mem_rw_q; wb_dst_d  = mem_dst_q;
      if (flush || stall) begin
        ex_valid_d = 1'b0; ex_rw_d = 1'b0; ex_load_d = 1'b0; ex_dst_d = '0;
`ifdef PIPELINE_HAZARD_FWD_EN
        ex_src_d  = '0;
        ex_used_d = '0;
`endif
      end else begin
        ex_valid_d = id_valid; ex_rw_d = id_reg_write; ex_load_d = id_mem_read;
        ex_dst_d   = id_dst_idx;
`ifdef PIPELINE_HAZARD_FWD_EN
        ex_src_d  = id_src_idx;
        ex_used_d = id_src_used;
`endif
      end
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    if (mem_busy)
      busy_cnt_d = (busy_cnt_q == BW'(MEM_TIMEOUT)) ? busy_cnt_q : busy_cnt_q + BW'(1);
    mem_err_d   = mem_err_q || (busy_cnt_d == BW'(MEM_TIMEOUT));
    stall_cnt_d = stall_cnt_q;
    if (run && (mem_busy || (data_stall && !ex_branch_taken)) && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      ex_valid_q  <= 1'b0; ex_rw_q  <= 1'b0; ex_load_q <= 1'b0; ex_dst_q <= '0;
      mem_valid_q <= 1'b0; mem_rw_q <= 1'b0; mem_dst_q <= '0;
      wb_valid_q  <= 1'b0; wb_rw_q  <= 1'b0; wb_dst_q  <= '0;
`ifdef PIPELINE_HAZARD_FWD_EN
      ex_src_q  <= '0;
      ex_used_q <= '0;
`endif
      busy_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_valid_q  <= ex_valid_d;  ex_rw_q  <= ex_rw_d;  ex_load_q <= ex_load_d; ex_dst_q <= ex_dst_d;
      mem_valid_q <= mem_valid_d; mem_rw_q <= mem_rw_d; mem_dst_q <= mem_dst_d;
      wb_valid_q  <= wb_valid_d;  wb_rw_q  <= wb_rw_d;  wb_dst_q  <= wb_dst_d;
`ifdef PIPELINE_HAZARD_FWD_EN
      ex_src_q  <= ex_src_d;
      ex_used_q <= ex_used_d;
`endif
      busy_cnt_q  <= busy_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit; expectations follow PIPELINE_HAZARD_FWD_EN when defined.
module tb_pipeline_hazard_unit;

  logic        clk = 1'b0;
  logic        rst, run, id_valid, id_reg_write, id_mem_read, ex_branch_taken, mem_busy;
  logic [11:0] id_src_idx;
  logic [2:0]  id_src_used;
  logic [3:0]  id_dst_idx;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_err;
  logic [5:0]  fwd_sel;
  logic [15:0] stall_cnt;

  pipeline_hazard_unit dut (
    .clk(clk), .rst(rst), .run(run), .id_valid(id_valid), .id_src_idx(id_src_idx),
    .id_src_used(id_src_used), .id_dst_idx(id_dst_idx), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .fwd_sel(fwd_sel), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ctl = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en}
  localparam logic [4:0] C_RUN = 5'b11001;
  localparam logic [4:0] C_STL = 5'b00011;
  localparam logic [4:0] C_FLS = 5'b11111;
  localparam logic [4:0] C_FRZ = 5'b00000;

  typedef struct {
    string       tag;
    logic [4:0]  ctl;
    logic [5:0]  fwd;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [4:0] c, input logic [5:0] f,
                            input logic e, input logic [15:0] n);
    exp_t x;
    x.tag = tag; x.ctl = c; x.fwd = f; x.err = e; x.cnt = n;
    sb.push_back(x);
  endtask

  task automatic compare_out();
    exp_t x;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue want an entry");
    end else begin
      x = sb.pop_front();
      check_val({x.tag, ".ctl"}, {27'd0, pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en},
                {27'd0, x.ctl});
      check_val({x.tag, ".fwd"}, {26'd0, fwd_sel}, {26'd0, x.fwd});
      check_val({x.tag, ".err"}, {31'd0, mem_err}, {31'd0, x.err});
      check_val({x.tag, ".cnt"}, {16'd0, stall_cnt}, {16'd0, x.cnt});
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                        input logic [2:0] used, input logic [3:0] dst, input logic rw,
                        input logic ld);
    id_valid = v; id_src_idx = {4'd0, s1, s0}; id_src_used = used;
    id_dst_idx = dst; id_reg_write = rw; id_mem_read = ld;
  endtask

  task automatic nop();
    set_id(1'b0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0);
  endtask

  // Called just after a rising edge; samples mid-cycle, then advances one clock.
  task automatic step(input string tag, input logic [4:0] c, input logic [5:0] f,
                      input logic e, input logic [15:0] n);
    expect_out(tag, c, f, e, n);
    #3;
    compare_out();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; run = 1'b1; mem_busy = 1'b0; ex_branch_taken = 1'b0;
    nop();
    #2;
    expect_out(tag, C_RUN, 6'd0, 1'b0, 16'd0);
    compare_out();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; mem_busy = 1'b0; ex_branch_taken = 1'b0;
    nop();
    #3;
    expect_out("por", C_RUN, 6'd0, 1'b0, 16'd0);
    compare_out();
    #4 rst = 1'b0;
    @(posedge clk);
    #1;

    // load r3, then add r5 = r3 + r4
    do_reset("rst_lu");
    set_id(1'b1, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b1);
    step("lu_load", C_RUN, 6'd0, 1'b0, 16'd0);
    set_id(1'b1, 4'd3, 4'd4, 3'b011, 4'd5, 1'b1, 1'b0);
    step("lu_stall", C_STL, 6'd0, 1'b0, 16'd0);
`ifdef PIPELINE_HAZARD_FWD_EN
    step("lu_go", C_RUN, 6'd0, 1'b0, 16'd1);
    nop();
    step("lu_fwd", C_RUN, 6'b000010, 1'b0, 16'd1);
`else
    step("lu_stall2", C_STL, 6'd0, 1'b0, 16'd1);
    step("lu_stall3", C_STL, 6'd0, 1'b0, 16'd2);
    step("lu_go", C_RUN, 6'd0, 1'b0, 16'd3);
    nop();
    step("lu_ex", C_RUN, 6'd0, 1'b0, 16'd3);
`endif

    // ALU writer of r2 followed by a reader of r2
    do_reset("rst_alu");
    set_id(1'b1, 4'd0, 4'd0, 3'b000, 4'd2, 1'b1, 1'b0);
    step("alu_wr", C_RUN, 6'd0, 1'b0, 16'd0);
    set_id(1'b1, 4'd2, 4'd0, 3'b001, 4'd6, 1'b1, 1'b0);
`ifdef PIPELINE_HAZARD_FWD_EN
    step("alu_rd", C_RUN, 6'd0, 1'b0, 16'd0);
    nop();
    step("alu_fwd1", C_RUN, 6'b000001, 1'b0, 16'd0);
    set_id(1'b1, 4'd0, 4'd0, 3'b000, 4'd2, 1'b1, 1'b0);
    step("gap_wr", C_RUN, 6'd0, 1'b0, 16'd0);
    nop();
    step("gap_nop", C_RUN, 6'd0, 1'b0, 16'd0);
    set_id(1'b1, 4'd2, 4'd0, 3'b001, 4'd7, 1'b1, 1'b0);
    step("gap_rd", C_RUN, 6'd0, 1'b0, 16'd0);
    nop();
    step("gap_fwd2", C_RUN, 6'b000010, 1'b0, 16'd0);
`else
    step("alu_stall1", C_STL, 6'd0, 1'b0, 16'd0);
    step("alu_stall2", C_STL, 6'd0, 1'b0, 16'd1);
    step("alu_stall3", C_STL, 6'd0, 1'b0, 16'd2);
    step("alu_go", C_RUN, 6'd0, 1'b0, 16'd3);
    nop();
    step("alu_nofwd", C_RUN, 6'd0, 1'b0, 16'd3);
`endif

    // taken branch coinciding with a load-use hazard
    do_reset("rst_br");
    set_id(1'b1, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b1);
    step("br_load", C_RUN, 6'd0, 1'b0, 16'd0);
    set_id(1'b1, 4'd3, 4'd0, 3'b001, 4'd5, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    step("br_flush", C_FLS, 6'd0, 1'b0, 16'd0);
    ex_branch_taken = 1'b0;
    nop();
    step("br_after", C_RUN, 6'd0, 1'b0, 16'd0);

    // r0 is never a dependency
    do_reset("rst_r0");
    set_id(1'b1, 4'd0, 4'd0, 3'b000, 4'd0, 1'b1, 1'b1);
    step("r0_load", C_RUN, 6'd0, 1'b0, 16'd0);
    set_id(1'b1, 4'd0, 4'd0, 3'b001, 4'd8, 1'b1, 1'b0);
    step("r0_rd", C_RUN, 6'd0, 1'b0, 16'd0);
    nop();
    step("r0_mem", C_RUN, 6'd0, 1'b0, 16'd0);
    step("r0_wb", C_RUN, 6'd0, 1'b0, 16'd0);

    // memory freeze with timeout
    do_reset("rst_mem");
    mem_busy = 1'b1;
    for (int i = 1; i <= 20; i++)
      step($sformatf("busy%0d", i), C_FRZ, 6'd0, (i > 15), 16'(i - 1));
    mem_busy = 1'b0;
    step("busy_done", C_RUN, 6'd0, 1'b1, 16'd20);
    run = 1'b0;
    step("run_off", C_FRZ, 6'd0, 1'b1, 16'd20);
    run = 1'b1;
    step("run_on", C_RUN, 6'd0, 1'b1, 16'd20);
    mem_busy = 1'b1;
    step("busy_again1", C_FRZ, 6'd0, 1'b1, 16'd20);
    step("busy_again2", C_FRZ, 6'd0, 1'b1, 16'd21);

    // asynchronous reset in the middle of the freeze
    do_reset("rst_mid_freeze");
    set_id(1'b1, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b1);
    step("post_rst", C_RUN, 6'd0, 1'b0, 16'd0);
    set_id(1'b1, 4'd3, 4'd0, 3'b001, 4'd5, 1'b1, 1'b0);
    step("post_rst_lu", C_STL, 6'd0, 1'b0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
